mem_bridge: RTL and testbench



---
 rtl/mem_bridge.sv | 157 +++++++++++++++
 tb/tb_mem_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// CPU-to-memory bridge: arbitrates instruction fetches and data accesses onto
// one single-port memory, with an ack timeout, a sticky error flag and a stall counter.
module mem_bridge #(
    parameter logic [7:0] MAX_WAIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_if_req,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_inst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IREQ = 2'd1,
        DREQ = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_inst;
    logic [31:0] r_rdata;
    logic [31:0] r_stall_cnt;
    logic        r_we;
    logic        r_err;
    logic        w_busy;
    logic        w_start;
    logic        w_data_req;
    logic        w_ack_go;
    logic        w_timeout;

    assign w_data_req = cpu_rd | cpu_wr;
    assign w_busy     = (r_state == IREQ) || (r_state == DREQ);
    assign w_start    = (r_state == IDLE) && (w_next != IDLE);

    // Next-state decode; data accesses win over fetches, timeout when the wait count hits MAX_WAIT.
    always_comb begin
        w_next    = r_state;
        w_ack_go  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_data_req) begin
                    w_next = DREQ;
                end else if (cpu_if_req) begin
                    w_next = IREQ;
                end else begin
                    w_next = IDLE;
                end
            end
            IREQ, DREQ: begin
                if (mem_ack) begin
                    w_ack_go = 1'b1;
                    w_next   = RESP;
                end else if (r_wait == MAX_WAIT) begin
                    w_timeout = 1'b1;
                    w_next    = RESP;
                end else begin
                    w_next = r_state;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch (held stable for the whole access) and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_we    <= 1'b0;
            r_wait  <= 8'd0;
        end else if (w_start) begin
            r_wait <= 8'd0;
            if (w_data_req) begin
                r_addr  <= {cpu_addr[31:2], 2'b00};
                r_we    <= cpu_wr;
                r_wdata <= cpu_wdata;
            end else begin
                r_addr <= {cpu_pc[31:2], 2'b00};
                r_we   <= 1'b0;
            end
        end else if (w_busy && !w_ack_go && !w_timeout) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    // Result registers: ack loads memory data, timeout loads zero and flags the error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst  <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_ack_go) begin
            if (r_state == IREQ) begin
                r_inst <= mem_rdata;
            end else if (!r_we) begin
                r_rdata <= mem_rdata;
            end
        end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_state == IREQ) begin
                r_inst <= 32'h0;
            end else if (!r_we) begin
                r_rdata <= 32'h0;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 32'h0;
        end else if (cpu_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign cpu_stall = ((r_state == IDLE) && (cpu_rd || cpu_wr || cpu_if_req)) || w_busy;
    assign mem_req   = w_busy;
    assign mem_we    = r_we && (r_state == DREQ);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_inst  = r_inst;
    assign cpu_rdata = r_rdata;
    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge (MAX_WAIT=4 so the timeout is reachable).
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_if_req;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_inst;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;
    logic [31:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    mem_bridge #(.MAX_WAIT(8'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_if_req (cpu_if_req),
        .cpu_pc     (cpu_pc),
        .cpu_inst   (cpu_inst),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .err        (err),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] b2b_data [3];

    initial begin
        b2b_data[0] = 32'hA000_0001;
        b2b_data[1] = 32'hB000_0002;
        b2b_data[2] = 32'hC000_0003;
        rst = 1'b0; cpu_if_req = 1'b0; cpu_pc = 32'h0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        step(); step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_inst", cpu_inst, 32'h0);
        chk("rst_err", {31'd0, err}, 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
        rst = 1'b1;
        step();

        // Fetch with ack in the second IREQ cycle.
        cpu_if_req = 1'b1; cpu_pc = 32'h0000_0010; #1;
        chk("f_stall_idle", {31'd0, cpu_stall}, 32'h1);
        step();
        chk("f_mem_req", {31'd0, mem_req}, 32'h1);
        chk("f_mem_addr", mem_addr, 32'h0000_0010);
        chk("f_mem_we", {31'd0, mem_we}, 32'h0);
        step();
        chk("f_still_req", {31'd0, mem_req}, 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h2408_0005;
        step();
        mem_ack = 1'b0; cpu_if_req = 1'b0; #1;
        chk("f_resp_stall", {31'd0, cpu_stall}, 32'h0);
        chk("f_resp_req", {31'd0, mem_req}, 32'h0);
        chk("f_cpu_inst", cpu_inst, 32'h2408_0005);
        chk("f_stall_cnt", stall_cnt, 32'd3);
        step();

        // Fetch and read together: data side first, word-aligned address.
        cpu_if_req = 1'b1; cpu_rd = 1'b1; cpu_addr = 32'h0000_0103;
        step();
        chk("c_mem_addr", mem_addr, 32'h0000_0100);
        chk("c_mem_we", {31'd0, mem_we}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        step();
        mem_ack = 1'b0; cpu_if_req = 1'b0; cpu_rd = 1'b0;
        chk("c_cpu_rdata", cpu_rdata, 32'hCAFE_0001);
        chk("c_cpu_inst_kept", cpu_inst, 32'h2408_0005);
        step();

        // Store with a simultaneous read request; write wins, load data untouched.
        cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'hDEAD_BEEF;
        step();
        chk("s_mem_we", {31'd0, mem_we}, 32'h1);
        chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("s_mem_addr", mem_addr, 32'h0000_0020);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_ack = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        chk("s_cpu_rdata_kept", cpu_rdata, 32'hCAFE_0001);
        chk("s_resp_we", {31'd0, mem_we}, 32'h0);
        step();

        // Stray ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        chk("i_ack_rdata", cpu_rdata, 32'hCAFE_0001);
        chk("i_ack_inst", cpu_inst, 32'h2408_0005);
        chk("i_ack_req", {31'd0, mem_req}, 32'h0);

        // Read timeout: wait count 0..4 spent in DREQ, then RESP with zero data.
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0040;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t_req_%0d", i), {31'd0, mem_req}, 32'h1);
            chk($sformatf("t_err_%0d", i), {31'd0, err}, 32'h0);
            step();
        end
        cpu_rd = 1'b0;
        chk("t_req_drop", {31'd0, mem_req}, 32'h0);
        chk("t_cpu_rdata", cpu_rdata, 32'h0);
        chk("t_err", {31'd0, err}, 32'h1);
        step();

        // Err stays set across a later successful fetch.
        cpu_if_req = 1'b1; cpu_pc = 32'h0000_0044;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0; cpu_if_req = 1'b0;
        chk("e_cpu_inst", cpu_inst, 32'h1111_2222);
        chk("e_err_sticky", {31'd0, err}, 32'h1);
        step();

        // Reset in the middle of a read.
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0080;
        step();
        chk("r_pre_req", {31'd0, mem_req}, 32'h1);
        rst = 1'b0; #1;
        chk("r_mem_req", {31'd0, mem_req}, 32'h0);
        chk("r_mem_addr", mem_addr, 32'h0);
        chk("r_cpu_inst", cpu_inst, 32'h0);
        chk("r_cpu_rdata", cpu_rdata, 32'h0);
        chk("r_err", {31'd0, err}, 32'h0);
        chk("r_stall_cnt", stall_cnt, 32'h0);
        step();
        cpu_rd = 1'b0; rst = 1'b1;
        step();

        // Three fetches back to back after reset.
        for (int k = 0; k < 3; k++) begin
            cpu_if_req = 1'b1; cpu_pc = 32'(4 * k);
            step();
            chk($sformatf("b_addr_%0d", k), mem_addr, 32'(4 * k));
            mem_ack = 1'b1; mem_rdata = b2b_data[k];
            step();
            mem_ack = 1'b0; cpu_if_req = 1'b0;
            chk($sformatf("b_inst_%0d", k), cpu_inst, b2b_data[k]);
            step();
        end
        chk("b_stall_cnt", stall_cnt, 32'd6);
        chk("b_err", {31'd0, err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
